// File: rtl/nmea_pkg.sv
// Shared definitions for the NMEA sentence transmitter and receiver:
// sentence state encoding, framing characters and nibble-to-hex mapping.
package nmea_pkg;

  localparam logic [3:0] ST_IDLE   = 4'd0;
  localparam logic [3:0] ST_DOLLAR = 4'd1;
  localparam logic [3:0] ST_TI     = 4'd2;
  localparam logic [3:0] ST_SI     = 4'd3;
  localparam logic [3:0] ST_DATA   = 4'd4;
  localparam logic [3:0] ST_STAR   = 4'd5;
  localparam logic [3:0] ST_HEX    = 4'd6;
  localparam logic [3:0] ST_CR     = 4'd7;
  localparam logic [3:0] ST_LF     = 4'd8;

  typedef enum logic [3:0] {
    S_IDLE   = ST_IDLE,
    S_DOLLAR = ST_DOLLAR,
    S_TI     = ST_TI,
    S_SI     = ST_SI,
    S_DATA   = ST_DATA,
    S_STAR   = ST_STAR,
    S_HEX    = ST_HEX,
    S_CR     = ST_CR,
    S_LF     = ST_LF
  } sent_state_e;

  localparam logic [7:0] CH_DOLLAR = 8'h24;
  localparam logic [7:0] CH_STAR   = 8'h2A;
  localparam logic [7:0] CH_CR     = 8'h0D;
  localparam logic [7:0] CH_LF     = 8'h0A;

  // Uppercase ASCII hex digit for one nibble.
  function automatic logic [7:0] nib2hex(input logic [3:0] nib);
    logic [7:0] n8;
    n8 = {4'h0, nib};
    if (nib < 4'd10) return 8'h30 + n8;
    return 8'h37 + n8;
  endfunction

endpackage

// File: rtl/uart_char_tx.sv
// 8N1 character serialiser: start bit, 8 data bits LSB first, stop bit,
// each held for the bit period captured at load time.
module uart_char_tx (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [9:0] i_baud,
  input  logic [7:0] i_char,
  input  logic       i_load,
  output logic       o_free,
  output logic       o_tx
);

  logic       busy;
  logic [3:0] bit_cnt;
  logic [9:0] baud_cnt;
  logic [9:0] baud_q;
  logic [8:0] shreg;
  logic       tx_q;
  logic       bit_end;

  assign bit_end = (baud_cnt == baud_q - 10'd1);
  // Free in the last stop-bit cycle too, so the next character follows directly.
  assign o_free  = !busy || (bit_end && (bit_cnt == 4'd9));
  assign o_tx    = tx_q;

  // Bit and baud counting with the line bit registered for a glitch-free output.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      busy     <= 1'b0;
      bit_cnt  <= '0;
      baud_cnt <= '0;
      baud_q   <= '0;
      shreg    <= '1;
      tx_q     <= 1'b1;
    end else if (i_load && o_free) begin
      busy     <= 1'b1;
      bit_cnt  <= '0;
      baud_cnt <= '0;
      baud_q   <= i_baud;
      shreg    <= {1'b1, i_char};
      tx_q     <= 1'b0;
    end else if (busy) begin
      if (bit_end) begin
        baud_cnt <= '0;
        if (bit_cnt == 4'd9) begin
          busy <= 1'b0;
          tx_q <= 1'b1;
        end else begin
          bit_cnt <= bit_cnt + 4'd1;
          tx_q    <= shreg[0];
          shreg   <= {1'b1, shreg[8:1]};
        end
      end else begin
        baud_cnt <= baud_cnt + 10'd1;
      end
    end
  end

endmodule

// File: rtl/nmea_tx.sv
// NMEA sentence transmitter: frames "$TTSSS<payload>*HH<CR><LF>" with an
// on-the-fly XOR checksum and serialises it through uart_char_tx.
module nmea_tx (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [9:0]  i_baud,
  input  logic        i_start,
  input  logic [15:0] i_talker,
  input  logic [23:0] i_sentence,
  input  logic [7:0]  i_data,
  input  logic        i_data_valid,
  input  logic        i_data_last,
  output logic        o_data_ready,
  output logic        o_ready,
  output logic        o_tx,
  output logic        o_done
);
  import nmea_pkg::*;

  sent_state_e state, state_nx;
  logic [1:0]  cnt, cnt_nx;
  logic [7:0]  csum;
  logic [15:0] talker_q;
  logic [23:0] sent_q;
  logic [9:0]  baud_q;
  logic        last_q;
  logic        done_q;
  logic        free;
  logic        load;
  logic        want_data;
  logic        add_csum;
  logic [7:0]  char_nx;
  logic [9:0]  baud_tx;

  // The state names the character currently on the line; the character mux
  // selects the one to hand over when the serialiser frees up, so '$' is
  // loaded on the accepting edge and characters stay back-to-back.
  always_comb begin
    load      = 1'b0;
    char_nx   = CH_DOLLAR;
    state_nx  = state;
    cnt_nx    = '0;
    want_data = 1'b0;
    add_csum  = 1'b0;
    case (state)
      S_IDLE: load = i_start;
      S_DOLLAR: begin
        char_nx  = talker_q[15:8];
        load     = free;
        add_csum = 1'b1;
        state_nx = S_TI;
      end
      S_TI: begin
        load     = free;
        add_csum = 1'b1;
        if (cnt == 2'd0) begin
          char_nx = talker_q[7:0];
          cnt_nx  = 2'd1;
        end else begin
          char_nx  = sent_q[23:16];
          state_nx = S_SI;
        end
      end
      S_SI: begin
        add_csum = 1'b1;
        if (cnt == 2'd2) begin
          want_data = 1'b1;
          char_nx   = i_data;
          load      = free && i_data_valid;
          state_nx  = S_DATA;
        end else begin
          load    = free;
          cnt_nx  = cnt + 2'd1;
          char_nx = (cnt == 2'd0) ? sent_q[15:8] : sent_q[7:0];
        end
      end
      S_DATA: begin
        if (last_q) begin
          char_nx  = CH_STAR;
          load     = free;
          state_nx = S_STAR;
        end else begin
          want_data = 1'b1;
          char_nx   = i_data;
          load      = free && i_data_valid;
          add_csum  = 1'b1;
        end
      end
      S_STAR: begin
        char_nx  = nib2hex(csum[7:4]);
        load     = free;
        state_nx = S_HEX;
      end
      S_HEX: begin
        load = free;
        if (cnt == 2'd0) begin
          char_nx = nib2hex(csum[3:0]);
          cnt_nx  = 2'd1;
        end else begin
          char_nx  = CH_CR;
          state_nx = S_CR;
        end
      end
      S_CR: begin
        char_nx  = CH_LF;
        load     = free;
        state_nx = S_LF;
      end
      default: load = 1'b0;
    endcase
  end

  assign o_data_ready = want_data && free;
  assign o_ready      = (state == S_IDLE);
  assign o_done       = done_q;
  assign baud_tx      = (state == S_IDLE) ? i_baud : baud_q;

  // Sentence sequencing, ID/baud capture and checksum accumulation.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state    <= S_IDLE;
      cnt      <= '0;
      csum     <= '0;
      talker_q <= '0;
      sent_q   <= '0;
      baud_q   <= '0;
      last_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (state == S_IDLE) begin
        if (i_start) begin
          talker_q <= i_talker;
          sent_q   <= i_sentence;
          baud_q   <= i_baud;
          csum     <= '0;
          last_q   <= 1'b0;
          cnt      <= '0;
          state    <= S_DOLLAR;
        end
      end else if (load) begin
        state <= state_nx;
        cnt   <= cnt_nx;
        if (add_csum) csum <= csum ^ char_nx;
        if (want_data) last_q <= i_data_last;
      end else if ((state == S_LF) && free) begin
        state  <= S_IDLE;
        done_q <= 1'b1;
      end
    end
  end

  uart_char_tx u_char_tx (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_baud (baud_tx),
    .i_char (char_nx),
    .i_load (load),
    .o_free (free),
    .o_tx   (o_tx)
  );

endmodule

// File: tb/tb_nmea_tx.sv
// Self-checking bench for nmea_tx: a sentence-level model expands each
// sentence into an expected per-cycle line/handshake trace.
module tb_nmea_tx;

  logic        clk = 1'b0;
  logic        i_rst, i_start, i_data_valid, i_data_last;
  logic [9:0]  i_baud;
  logic [15:0] i_talker;
  logic [23:0] i_sentence;
  logic [7:0]  i_data;
  logic        o_data_ready, o_ready, o_tx, o_done;

  always #5 clk = ~clk;

  nmea_tx dut (
    .i_clk(clk), .i_rst(i_rst), .i_baud(i_baud), .i_start(i_start),
    .i_talker(i_talker), .i_sentence(i_sentence), .i_data(i_data),
    .i_data_valid(i_data_valid), .i_data_last(i_data_last),
    .o_data_ready(o_data_ready), .o_ready(o_ready), .o_tx(o_tx), .o_done(o_done)
  );

  typedef struct packed { logic tx; logic dr; logic done; logic rdy; } rec_t;
  rec_t       exp_q[$];
  rec_t       cur;
  logic [7:0] pay_b[$];
  logic       pay_l[$];
  int         pay_g[$];
  logic [7:0] pay_bytes[16];
  int         tests = 0, fails = 0, consumed = 0, lat;
  logic [7:0] m_csum;
  string      m_str;
  time        t_acc;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      if (fails <= 40) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expand one sentence into expected per-cycle records and queue its payload.
  task automatic model_push(input logic [15:0] ti, input logic [23:0] si, input int baud,
                            input int n, input int gi, input int gl);
    logic [7:0] ch[32];
    logic [7:0] ids[5];
    logic [7:0] cs;
    string      hexd;
    int         nc, bi, g;
    bit         nxt_pay;
    rec_t       r;
    hexd = "0123456789ABCDEF";
    ids  = '{ti[15:8], ti[7:0], si[23:16], si[15:8], si[7:0]};
    cs = 8'h00; nc = 1; ch[0] = 8'h24;
    for (int i = 0; i < 5; i++) begin ch[nc] = ids[i]; cs ^= ids[i]; nc++; end
    for (int i = 0; i < n; i++) begin
      ch[nc] = pay_bytes[i]; cs ^= pay_bytes[i]; nc++;
      pay_b.push_back(pay_bytes[i]);
      pay_l.push_back(i == n - 1);
      pay_g.push_back((i == gi) ? gl : 0);
    end
    ch[nc] = 8'h2A; ch[nc+1] = hexd[cs[7:4]]; ch[nc+2] = hexd[cs[3:0]];
    ch[nc+3] = 8'h0D; ch[nc+4] = 8'h0A; nc += 5;
    m_str = "";
    for (int k = 0; k < nc; k++) begin
      m_str   = $sformatf("%s%c", m_str, ch[k]);
      nxt_pay = (k + 1 >= 6) && (k + 1 < 6 + n);
      g       = (nxt_pay && (k + 1 - 6 == gi)) ? gl : 0;
      for (int c = 0; c < 10 * baud; c++) begin
        bi   = c / baud;
        r.tx = (bi == 0) ? 1'b0 : (bi == 9) ? 1'b1 : ch[k][bi-1];
        r.dr = nxt_pay && (c == 10 * baud - 1);
        r.done = 1'b0; r.rdy = 1'b0;
        exp_q.push_back(r);
      end
      for (int j = 0; j < g; j++) exp_q.push_back('{tx: 1'b1, dr: 1'b1, done: 1'b0, rdy: 1'b0});
    end
    exp_q.push_back('{tx: 1'b1, dr: 1'b0, done: 1'b1, rdy: 1'b1});
    m_csum = cs;
  endtask

  // Per-cycle comparison against the model trace; idle expectations otherwise.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      cur = exp_q.pop_front();
      check("line_tx", o_tx, cur.tx);
      check("line_data_ready", o_data_ready, cur.dr);
      check("line_done", o_done, cur.done);
      check("line_ready", o_ready, cur.rdy);
    end else begin
      check("idle_tx", o_tx, 1);
      check("idle_done", o_done, 0);
      check("idle_data_ready", o_data_ready, 0);
      check("idle_ready", o_ready, 1);
    end
  end

  // Payload producer: honours per-byte gaps counted in data-ready cycles.
  initial begin
    bit hs, rd;
    i_data_valid = 1'b0; i_data = '0; i_data_last = 1'b0;
    forever begin
      @(negedge clk);
      hs = i_data_valid && o_data_ready;
      rd = o_data_ready;
      @(posedge clk); #1;
      if (hs && pay_b.size() > 0) begin
        void'(pay_b.pop_front()); void'(pay_l.pop_front()); void'(pay_g.pop_front());
        consumed++;
      end else if (rd && pay_g.size() > 0 && pay_g[0] > 0) begin
        pay_g[0] = pay_g[0] - 1;
      end
      if (pay_b.size() > 0 && pay_g[0] == 0) begin
        i_data_valid = 1'b1; i_data = pay_b[0]; i_data_last = pay_l[0];
      end else begin
        i_data_valid = 1'b0; i_data = 8'h00; i_data_last = 1'b0;
      end
    end
  end

  task automatic start_sentence(input logic [15:0] ti, input logic [23:0] si, input int baud,
                                input int n, input int gi, input int gl);
    @(posedge clk); #1;
    i_talker = ti; i_sentence = si; i_baud = baud[9:0]; i_start = 1'b1;
    @(posedge clk);
    model_push(ti, si, baud, n, gi, gl);
    t_acc = $time;
    #1 i_start = 1'b0;
  endtask

  task automatic wait_done(output int l);
    int k;
    k = 0;
    l = -1;
    while (k < 20000) begin
      @(negedge clk); k++;
      if (o_done) break;
    end
    check("done_timeout", o_done, 1);
    if (o_done) l = int'(($time - t_acc - 5) / 10);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    i_rst = 1'b0; i_start = 1'b0; i_baud = 10'd4; i_talker = '0; i_sentence = '0;
    #12;
    check("rst_tx", o_tx, 1);
    check("rst_ready", o_ready, 1);
    check("rst_data_ready", o_data_ready, 0);
    check("rst_done", o_done, 0);
    @(posedge clk); #2 i_rst = 1'b1;

    // Basic sentence, payload always valid.
    pay_bytes[0] = ","; pay_bytes[1] = "1"; consumed = 0;
    start_sentence("GP", "GGA", 4, 2, -1, 0);
    tests++;
    if (m_str != "$GPGGA,1*4B\r\n") begin
      fails++; $display("FAIL model_string: got %s expected $GPGGA,1*4B", m_str);
    end
    check("model_csum_gga", m_csum, 8'h4B);
    wait_done(lat);
    check("latency_gga", lat, 520);
    check("consumed_gga", consumed, 2);

    // 37-cycle producer gap before the first payload byte.
    start_sentence("GP", "GGA", 4, 2, 0, 37);
    wait_done(lat);
    check("latency_gap", lat, 557);

    // Checksum nibble coverage at the minimum bit period.
    pay_bytes[0] = "A";
    start_sentence("GP", "RMC", 2, 1, -1, 0);
    check("model_csum_rmc", m_csum, 8'h0A);
    wait_done(lat);
    check("latency_rmc", lat, 240);
    for (int n = 0; n < 16; n++) begin
      logic [3:0] nb;
      nb = n[3:0];
      pay_bytes[0] = 8'h4B ^ {nb, nb};
      start_sentence("GP", "RMC", 2, 1, -1, 0);
      check("model_csum_nib", m_csum, {nb, nb});
      wait_done(lat);
    end

    // Mid-sentence i_start pulse and ID/baud changes are ignored.
    pay_bytes[0] = ","; pay_bytes[1] = "1";
    start_sentence("GP", "GGA", 3, 2, -1, 0);
    repeat (100) @(posedge clk);
    #1 i_start = 1'b1; i_baud = 10'd7; i_talker = "XX"; i_sentence = "ZZZ";
    @(posedge clk); #1 i_start = 1'b0;
    wait_done(lat);
    check("latency_ignore", lat, 390);
    repeat (40) @(negedge clk);

    // Asynchronous reset during the start bit of a payload character.
    pay_bytes[0] = ","; pay_bytes[1] = "1"; pay_bytes[2] = "2"; pay_bytes[3] = "3";
    start_sentence("GP", "GGA", 4, 4, -1, 0);
    repeat (241) @(posedge clk);
    #3;
    check("pre_rst_tx", o_tx, 0);
    exp_q.delete(); pay_b.delete(); pay_l.delete(); pay_g.delete();
    i_rst = 1'b0;
    #1;
    check("async_rst_tx", o_tx, 1);
    check("async_rst_ready", o_ready, 1);
    check("async_rst_data_ready", o_data_ready, 0);
    repeat (3) @(posedge clk);
    #2 i_rst = 1'b1;
    pay_bytes[0] = ","; pay_bytes[1] = "1";
    start_sentence("GP", "GGA", 4, 2, -1, 0);
    wait_done(lat);
    check("latency_after_rst", lat, 520);

    // Back-to-back sentences with i_start held through o_done.
    @(posedge clk); #1;
    i_talker = "GP"; i_sentence = "GGA"; i_baud = 10'd4; i_start = 1'b1;
    @(posedge clk);
    pay_bytes[0] = ","; pay_bytes[1] = "1";
    model_push("GP", "GGA", 4, 2, -1, 0);
    pay_bytes[0] = ","; pay_bytes[1] = "X"; pay_bytes[2] = ","; pay_bytes[3] = "9";
    model_push("GN", "GLL", 2, 4, -1, 0);
    t_acc = $time;
    #1 i_talker = "GN"; i_sentence = "GLL"; i_baud = 10'd2;
    repeat (521) @(posedge clk);
    #1 i_start = 1'b0;
    for (int k = 0; k < 2000 && exp_q.size() > 0; k++) @(negedge clk);
    check("b2b_drained", exp_q.size(), 0);
    check("b2b_payload_used", pay_b.size(), 0);
    repeat (20) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/nmea_tx.md
# nmea_tx

Sentence-level transmitter for the NMEA-style serial link, the counterpart of the sentence receiver. It accepts a talker ID, a sentence ID and a streamed payload, and computes the XOR checksum on the fly. It serialises the complete sentence "$TTSSS<payload>*HH<CR><LF>" as 8N1 UART characters on one line. It sits between the host-side sentence producer and the board serial output.

## Interface
- No parameters; bit period supplied at run time via i_baud.
- i_clk  in  1  system clock.
- i_rst  in  1  reset, asynchronous, active-low.
- i_baud  in  10  clock cycles per UART bit; legal 2..1023; latched when a sentence is accepted.
- i_start  in  1  begin sentence; accepted only when o_ready=1.
- i_talker  in  16  talker ID, [15:8] first char, [7:0] second; sampled on accept.
- i_sentence  in  24  sentence ID, [23:16] first char; sampled on accept.
- i_data  in  8  payload byte.
- i_data_valid  in  1  payload byte valid.
- i_data_last  in  1  qualifies i_data as final payload byte.
- o_data_ready  out  1  payload byte taken this cycle when i_data_valid=1.
- o_ready  out  1  idle, may accept i_start.
- o_tx  out  1  serial line, idle high.
- o_done  out  1  one-cycle pulse, sentence fully sent.

## Operation
- Sentence FSM: IDLE -> DOLLAR -> TI (2 chars) -> SI (3 chars) -> DATA -> STAR -> HEX (2 chars) -> CR -> LF -> IDLE.
- IDLE: o_ready=1. i_start=1 latches talker, sentence and baud, clears checksum to 8'h00, goes to DOLLAR.
- Each state hands one character to the char transmitter when it is free and advances when that character is taken. Char count is held in a 2-bit counter for TI/SI/HEX and wraps to 0 on state exit.
- Checksum = XOR of every TI, SI and payload character. '$', '*', hex digits, CR and LF are excluded.
- DATA: o_data_ready=1 only while the char transmitter is free. A byte is consumed on i_data_valid & o_data_ready. If i_data_last=1 on that byte, next state is STAR. While no byte is valid, o_tx idles high between characters; gaps are legal.
- Payload has at least one byte; framing commas are part of the payload. Bytes are sent unmodified; the producer guarantees no '$', '*', CR or LF.
- HEX: high nibble first. A nibble n<10 maps to 8'h30+n; n>=10 maps to 8'h41+n-10 (uppercase).
- i_start while o_ready=0 is ignored. i_talker, i_sentence and i_baud changes mid-sentence have no effect.
- The char transmitter sends an 8N1 character: start bit 0, data LSB first, stop bit 1. Each bit is held i_baud cycles, so one character is 10*i_baud cycles.

## Timing
- Reset: o_tx=1, o_ready=1, o_data_ready=0, o_done=0, FSM in IDLE, checksum 0. Reset mid-sentence aborts immediately, and o_tx returns high asynchronously.
- o_tx falls for the '$' start bit on the cycle after the accepting i_start edge.
- Characters are back-to-back with zero idle cycles whenever the next character is available. The next start bit follows the last stop-bit cycle directly.
- Total sentence time with payload always valid: (N+11)*10*i_baud cycles, where N = payload length.
- o_data_ready is asserted for exactly one cycle per consumed byte, in the cycle the char transmitter loads it.
- o_done pulses the cycle after the LF stop bit ends. o_ready=1 in that same cycle, and an i_start then is accepted with no gap.
- i_data_valid dropping while o_data_ready=0 loses nothing.

## Structure
- Shared package nmea_pkg: sentence state enum, character constants ('$' 8'h24, '*' 8'h2A, CR 8'h0D, LF 8'h0A) and a nibble-to-ASCII-hex function. The receiver reuses the package.
- Sub-module uart_char_tx: i_clk, i_rst, i_baud, i_char, i_load, o_free, o_tx. It holds the bit counter and baud counter; o_free=1 when it can load this cycle, including the final stop-bit cycle.
- The top holds the FSM, the char counter, the checksum register, the latched IDs and the character mux.

## Test plan
- i_baud=4, TI "GP", SI "GGA", payload ",1" always valid -> o_tx carries "$GPGGA,1*4B\r\n", 13 chars, 520 cycles start-to-done. Checksum 8'h4B.
- Same sentence with i_data_valid low for 37 cycles before ',' -> identical bytes and o_tx high during the gap. o_done is 37 cycles later.
- TI "GP", SI "RMC", payload "A" -> checksum nibbles 0x0..0xF checked against the reference model. Uppercase hex digits emitted.
- i_start pulsed mid-sentence and i_baud changed mid-sentence -> current sentence unaffected. No second sentence is started.
- i_rst asserted during a payload character -> o_tx=1, o_ready=1 immediately. The next sentence after release is bit-exact.
- Two sentences back-to-back (i_start held high through o_done) -> the second '$' start bit directly follows the first LF stop bit.
